// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - time-multiplexed seven-segment scan controller
// Prescaled one-cold digit scan with frame-coherent shadowing of codes, blanks and points.
module ssd_scan_ctrl #(
   parameter int DIGITS = 4,
   parameter int DIV    = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   digits_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [3:0]            o,
   output logic                  dp,
   output logic [DIGITS-1:0]     ssd_ctrl,
   output logic                  frame_tick
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         pcnt_q, pcnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   sh_dig_q, sh_dig_d;
   logic [DIGITS-1:0]     sh_blank_q, sh_blank_d;
   logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
   logic [3:0]            o_q, o_d;
   logic                  dp_q, dp_d;
   logic [DIGITS-1:0]     ssd_q, ssd_d;
   logic                  tick_q;

   logic                  load;
   logic                  lit;
   logic [3:0]            cur_dig;
   logic                  cur_blank;
   logic                  cur_dp;
   logic [DIGITS-1:0]     cold;

   // Select the shadowed data of the digit currently addressed by idx_q.
   always_comb begin
      cur_dig   = '0;
      cur_blank = 1'b0;
      cur_dp    = 1'b0;
      cold      = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_dig   = sh_dig_q[4*i +: 4];
            cur_blank = sh_blank_q[i];
            cur_dp    = sh_dp_q[i];
            cold[i]   = 1'b0;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      pcnt_d     = pcnt_q;
      idx_d      = idx_q;
      load       = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = SCAN;
               pcnt_d  = '0;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         default: begin
            if (en) begin
               if (pcnt_q == P_LAST) begin
                  pcnt_d = '0;
                  if (idx_q == I_LAST) begin
                     idx_d = '0;
                     load  = 1'b1;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
                  pcnt_d = pcnt_q + PW'(1);
               end
            end
         end
      endcase

      sh_dig_d   = load ? digits_in : sh_dig_q;
      sh_blank_d = load ? blank_in  : sh_blank_q;
      sh_dp_d    = load ? dp_in     : sh_dp_q;

      // Output decode uses pre-edge state, giving one cycle of latency.
      lit   = (state_q == SCAN) && en && !cur_blank;
      o_d   = cur_dig;
      dp_d  = lit && cur_dp;
      ssd_d = lit ? cold : '1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pcnt_q     <= '0;
         idx_q      <= '0;
         sh_dig_q   <= '0;
         sh_blank_q <= '0;
         sh_dp_q    <= '0;
         o_q        <= '0;
         dp_q       <= 1'b0;
         ssd_q      <= '1;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcnt_q     <= pcnt_d;
         idx_q      <= idx_d;
         sh_dig_q   <= sh_dig_d;
         sh_blank_q <= sh_blank_d;
         sh_dp_q    <= sh_dp_d;
         o_q        <= o_d;
         dp_q       <= dp_d;
         ssd_q      <= ssd_d;
         tick_q     <= load;
      end
   end

   assign o          = o_q;
   assign dp         = dp_q;
   assign ssd_ctrl   = ssd_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - scoreboard bench for ssd_scan_ctrl
module tb_ssd_scan_ctrl;

   typedef struct packed {
      logic [3:0] ssd;
      logic [3:0] o;
      logic       dp;
      logic       tk;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [15:0] digits = 16'h0;
   logic [3:0]  blank  = 4'h0;
   logic [3:0]  dpm    = 4'h0;
   logic [3:0]  o;
   logic        dp;
   logic [3:0]  ssd_ctrl;
   logic        frame_tick;

   logic        rst2 = 1'b1;
   logic        en2  = 1'b0;
   logic [7:0]  digits2 = 8'h5a;
   logic [3:0]  o2;
   logic        dp2;
   logic [1:0]  ssd2;
   logic        tick2;

   exp_t exp_q[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ssd_scan_ctrl #(.DIGITS(4), .DIV(4)) dut (
      .clk(clk), .rst(rst), .en(en), .digits_in(digits), .blank_in(blank), .dp_in(dpm),
      .o(o), .dp(dp), .ssd_ctrl(ssd_ctrl), .frame_tick(frame_tick));

   ssd_scan_ctrl #(.DIGITS(2), .DIV(1)) dut2 (
      .clk(clk), .rst(rst2), .en(en2), .digits_in(digits2), .blank_in(2'b00), .dp_in(2'b00),
      .o(o2), .dp(dp2), .ssd_ctrl(ssd2), .frame_tick(tick2));

   // Leaves rst low and en high at a falling edge; the next rising edge is the first load.
   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) rst = 1'b0;
         exp_q.push_back({4'b1111, 4'h0, 1'b0, 1'b0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({ssd_ctrl, o, dp, frame_tick} !== e) begin
            n_err++;
            $display("FAIL reset k=%0d got ssd=%b o=%h dp=%b tk=%b want ssd=%b o=%h dp=%b tk=%b",
                     k, ssd_ctrl, o, dp, frame_tick, e.ssd, e.o, e.dp, e.tk);
         end
      end
   endtask

   task automatic test_start();
      int d;
      digits = 16'h4321;
      blank  = 4'h0;
      dpm    = 4'h0;
      do_reset();
      for (int k = 0; k <= 40; k++) begin
         d = ((k - 1) / 4) % 4;
         if (k == 0) exp_q.push_back({4'b1111, 4'h0, 1'b0, 1'b1});
         else        exp_q.push_back({~(4'b0001 << d), 4'(d + 1), 1'b0, (k % 16) == 0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({ssd_ctrl, o, dp, frame_tick} !== e) begin
            n_err++;
            $display("FAIL start k=%0d got ssd=%b o=%h dp=%b tk=%b want ssd=%b o=%h dp=%b tk=%b",
                     k, ssd_ctrl, o, dp, frame_tick, e.ssd, e.o, e.dp, e.tk);
         end
      end
   endtask

   task automatic test_shadow();
      int d;
      digits = 16'h4321;
      do_reset();
      for (int k = 0; k <= 32; k++) begin
         d = ((k - 1) / 4) % 4;
         if (k == 0)       exp_q.push_back({4'b1111, 4'h0, 1'b0, 1'b1});
         else if (k <= 16) exp_q.push_back({~(4'b0001 << d), 4'(d + 1), 1'b0, k == 16});
         else              exp_q.push_back({~(4'b0001 << d), 4'(d + 5), 1'b0, k == 32});
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({ssd_ctrl, o, dp, frame_tick} !== e) begin
            n_err++;
            $display("FAIL shadow k=%0d got ssd=%b o=%h dp=%b tk=%b want ssd=%b o=%h dp=%b tk=%b",
                     k, ssd_ctrl, o, dp, frame_tick, e.ssd, e.o, e.dp, e.tk);
         end
         if (k == 6) digits = 16'h8765;
      end
   endtask

   task automatic test_blank_dp();
      int d;
      digits = 16'h4321;
      blank  = 4'b0100;
      dpm    = 4'b0010;
      do_reset();
      for (int k = 0; k <= 20; k++) begin
         d = ((k - 1) / 4) % 4;
         if (k == 0)      exp_q.push_back({4'b1111, 4'h0, 1'b0, 1'b1});
         else if (d == 2) exp_q.push_back({4'b1111, 4'h3, 1'b0, 1'b0});
         else             exp_q.push_back({~(4'b0001 << d), 4'(d + 1), d == 1, (k % 16) == 0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({ssd_ctrl, o, dp, frame_tick} !== e) begin
            n_err++;
            $display("FAIL blank_dp k=%0d got ssd=%b o=%h dp=%b tk=%b want ssd=%b o=%h dp=%b tk=%b",
                     k, ssd_ctrl, o, dp, frame_tick, e.ssd, e.o, e.dp, e.tk);
         end
      end
      blank = 4'h0;
      dpm   = 4'h0;
   endtask

   task automatic test_pause();
      int d;
      int kk;
      digits = 16'h4321;
      do_reset();
      for (int k = 0; k <= 30; k++) begin
         kk = (k >= 12) ? k - 5 : k;
         d  = ((kk - 1) / 4) % 4;
         if (k == 0)                exp_q.push_back({4'b1111, 4'h0, 1'b0, 1'b1});
         else if (k >= 7 && k <= 11) exp_q.push_back({4'b1111, 4'h2, 1'b0, 1'b0});
         else                       exp_q.push_back({~(4'b0001 << d), 4'(d + 1), 1'b0, k == 21});
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({ssd_ctrl, o, dp, frame_tick} !== e) begin
            n_err++;
            $display("FAIL pause k=%0d got ssd=%b o=%h dp=%b tk=%b want ssd=%b o=%h dp=%b tk=%b",
                     k, ssd_ctrl, o, dp, frame_tick, e.ssd, e.o, e.dp, e.tk);
         end
         if (k == 6)  en = 1'b0;
         if (k == 11) en = 1'b1;
      end
   endtask

   task automatic test_async_reset();
      int d;
      digits = 16'h4321;
      do_reset();
      repeat (14) @(negedge clk);
      #2;
      rst    = 1'b1;
      digits = 16'h8765;
      #1;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back({4'b1111, 4'h0, 1'b0, 1'b0});
         if (k == 1) @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({ssd_ctrl, o, dp, frame_tick} !== e) begin
            n_err++;
            $display("FAIL async_rst k=%0d got ssd=%b o=%h dp=%b tk=%b want ssd=%b o=%h dp=%b tk=%b",
                     k, ssd_ctrl, o, dp, frame_tick, e.ssd, e.o, e.dp, e.tk);
         end
      end
      rst = 1'b0;
      for (int k = 0; k <= 20; k++) begin
         d = ((k - 1) / 4) % 4;
         if (k == 0) exp_q.push_back({4'b1111, 4'h0, 1'b0, 1'b1});
         else        exp_q.push_back({~(4'b0001 << d), 4'(d + 5), 1'b0, k == 16});
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({ssd_ctrl, o, dp, frame_tick} !== e) begin
            n_err++;
            $display("FAIL restart k=%0d got ssd=%b o=%h dp=%b tk=%b want ssd=%b o=%h dp=%b tk=%b",
                     k, ssd_ctrl, o, dp, frame_tick, e.ssd, e.o, e.dp, e.tk);
         end
      end
   endtask

   task automatic test_degenerate();
      rst2 = 1'b1;
      en2  = 1'b0;
      repeat (2) @(negedge clk);
      rst2 = 1'b0;
      en2  = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         if (k == 0)          exp_q.push_back({4'b0011, 4'h0, 1'b0, 1'b1});
         else if (k % 2 == 1) exp_q.push_back({4'b0010, 4'ha, 1'b0, 1'b0});
         else                 exp_q.push_back({4'b0001, 4'h5, 1'b0, 1'b1});
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({2'b00, ssd2, o2, dp2, tick2} !== e) begin
            n_err++;
            $display("FAIL degenerate k=%0d got ssd=%b o=%h dp=%b tk=%b want ssd=%b o=%h dp=%b tk=%b",
                     k, ssd2, o2, dp2, tick2, e.ssd[1:0], e.o, e.dp, e.tk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_shadow();
      test_blank_dp();
      test_pause();
      test_async_reset();
      test_degenerate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Parametrised time-multiplexed seven-segment scan controller: drives `DIGITS` common-anode digits from one shared 4-bit code bus, with active-low one-cold digit enables. It generalises the two-digit enable-driven digit mux with an internal refresh prescaler, digit index counter, per-digit blanking and decimal point, and frame-coherent shadowing. It sits between the display-value logic and the BCD-to-segment decoder feeding the board pins.

## Interface
- `DIGITS`, 4: number of digits scanned; legal range 2..8.
- `DIV`, 100000: clock cycles each digit is lit; legal minimum 1 (advance every cycle).
- `clk` input 1: system clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: scan enable; low freezes scanning and blanks the display.
- `digits_in` input 4*DIGITS: digit codes; digit i is `[4i+3:4i]`, digit 0 is rightmost.
- `blank_in` input DIGITS: bit i high forces digit i dark.
- `dp_in` input DIGITS: bit i high lights the decimal point of digit i.
- `o` output 4: code of the currently lit digit, to the segment decoder.
- `dp` output 1: decimal point for the currently lit digit, active-high.
- `ssd_ctrl` output DIGITS: digit enables, active-low; at most one bit low.
- `frame_tick` output 1: one-cycle pulse at each shadow load.

## Operation
- Prescaler `pcnt` (width max(1, clog2(DIV))) counts 0..DIV-1 while scanning and `en`=1. Terminal count (`tc`) is `pcnt`=DIV-1; `pcnt` wraps to 0 on `tc`.
- Digit index `idx` increments on `tc`, DIGITS-1 wraps to 0.
- Shadow registers `sh_dig`, `sh_blank`, `sh_dp` capture `digits_in`, `blank_in`, `dp_in`. Displayed data changes only at a load, so there is no tearing within a frame.
- The state machine has two states: IDLE (after reset) and SCAN.
  - IDLE to SCAN: on the first cycle with `en`=1. That cycle performs a load, and sets `idx`=0 and `pcnt`=0.
  - In SCAN, a load also occurs on the `tc` cycle where `idx`=DIGITS-1, together with the `idx` wrap to 0.
  - There is no return to IDLE except through `rst`.
- `frame_tick` is registered high for exactly the cycle after each load edge.
- `en`=0 in SCAN:
  - `pcnt`, `idx` and the shadows hold.
  - On resume, counting continues from the held values; no reload occurs.
- Output decode, computed from registered state:
  - If state is IDLE, or `en`=0, or `sh_blank[idx]`=1: `ssd_ctrl` is all ones and `dp`=0.
  - Otherwise: `ssd_ctrl` has only bit `idx` low and `dp`=`sh_dp[idx]`.
  - In all cases, `o`=`sh_dig[4*idx+:4]`.
  - `o`, `dp` and `ssd_ctrl` are output registers loaded from this decode.

## Timing
- Reset values, applied immediately when `rst` rises: state IDLE, `pcnt`=0, `idx`=0, shadows 0, `o`=0, `dp`=0, `ssd_ctrl` all ones, `frame_tick`=0.
- Output latency:
  - State registers update on edge k; outputs reflect them on edge k+1.
  - First lit digit: `en` is sampled high at edge e0 (load). `ssd_ctrl` bit 0 goes low after edge e0+1, provided it is not blanked.
- Each digit is lit for exactly DIV cycles, so a full frame is DIGITS*DIV cycles.
- `en` falling edge: `ssd_ctrl` goes all ones one cycle later. `en` rising edge: the held digit relights one cycle later for its remaining `pcnt` count.
- Input changes between loads have no effect on the outputs.
- Reset mid-frame aborts immediately. Scanning restarts at digit 0 with a fresh load on the next `en`=1 cycle after `rst` falls.
- DIV=1: `idx` advances every enabled cycle, and a load occurs every DIGITS cycles.

## Test plan
- **Reset and start.** With DIGITS=4, DIV=4, `digits_in`=16'h4321, masks 0, hold `rst` for 3 cycles, then `en`=1.
  - `ssd_ctrl` stays 4'b1111 until one cycle after the first enabled edge.
  - Then the pattern is 4'b1110/`o`=1 (4 cycles), 4'b1101/`o`=2, 4'b1011/`o`=3, 4'b0111/`o`=4, repeating.
  - `frame_tick` pulses every 16 cycles.
- **Shadowing.** Change `digits_in` to 16'h8765 while digit 1 is lit.
  - Digits 2 and 3 still show 3 and 4.
  - The new values appear from digit 0 after the next `frame_tick`.
- **Blank and decimal point.** Apply `blank_in`=4'b0100 and `dp_in`=4'b0010 before a load.
  - During digit 2's slot, `ssd_ctrl`=4'b1111.
  - `dp`=1 only during digit 1's slot.
- **Enable pause.** Drop `en` for 5 cycles during digit 1, cycle 2.
  - `ssd_ctrl`=4'b1111 one cycle after `en` falls.
  - On resume, digit 1 relights for its remaining 2 cycles; the total frame length becomes 21 cycles.
- **Asynchronous reset mid-scan.** Assert `rst` between clock edges during digit 3.
  - Outputs go to their reset values before the next edge.
  - After release, the first enabled edge loads and the scan starts at digit 0.
- **Degenerate configuration.** With DIGITS=2, DIV=1:
  - `ssd_ctrl` alternates 2'b10/2'b01 every cycle.
  - `frame_tick` asserts every 2 cycles.
